// File: rtl/bitnet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitnet_pkg
// Purpose  : Shared types and defaults for the propagation sequencer: the
//            sequencer state encoding and the default lane / counter widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bitnet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FWD  = 3'd1,
    ST_LOSS = 3'd2,
    ST_BWD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int LANES_DEF = 3;
  localparam int CNT_W_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/prop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prop_sequencer
// Purpose  : Sequences one training sample through a chain of unit layers:
//            forward enables ascending, one loss cycle computing the error
//            vector, backward enables descending, then a done pulse and
//            sample / mismatch statistics.
// Ports    : clk_in, rst_in (sync, active high)
//            start_in, infer_only_in, abort_in, target_in, net_in  - control/data in
//            fd_prop_out, bk_prop_out  - one-hot layer enables
//            err_out, busy_out, done_out, mismatch_out             - status/data out
//            sample_cnt_out, mismatch_cnt_out                      - statistics
// Revision : 1.0 - initial release
// ============================================================================
module prop_sequencer
  import bitnet_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int LANES      = LANES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  infer_only_in,
  input  logic                  abort_in,
  input  logic [LANES-1:0]      target_in,
  input  logic [LANES-1:0]      net_in,
  output logic [NUM_LAYERS-1:0] fd_prop_out,
  output logic [NUM_LAYERS-1:0] bk_prop_out,
  output logic [LANES-1:0]      err_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  mismatch_out,
  output logic [CNT_W-1:0]      sample_cnt_out,
  output logic [CNT_W-1:0]      mismatch_cnt_out
);

  localparam int                    IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IDX_W-1:0]      C_LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [NUM_LAYERS-1:0] C_ONE      = NUM_LAYERS'(1);

  state_t                r_state,  w_state_nxt;
  logic [IDX_W-1:0]      r_idx,    w_idx_nxt;
  logic [LANES-1:0]      r_target, w_target_nxt;
  logic                  r_infer,  w_infer_nxt;
  logic [NUM_LAYERS-1:0] w_fd_nxt, w_bk_nxt;
  logic [LANES-1:0]      w_err_nxt;
  logic                  w_done_nxt, w_mis_nxt;
  logic [CNT_W-1:0]      w_scnt_nxt, w_mcnt_nxt;

  // All outputs are registered: the combinational process computes the value
  // each output must show in the cycle after the edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_target_nxt = r_target;
    w_infer_nxt  = r_infer;
    w_fd_nxt     = '0;
    w_bk_nxt     = '0;
    w_err_nxt    = err_out;
    w_done_nxt   = 1'b0;
    w_mis_nxt    = mismatch_out;
    w_scnt_nxt   = sample_cnt_out;
    w_mcnt_nxt   = mismatch_cnt_out;

    case (r_state)
      ST_IDLE: begin
        if (start_in && !abort_in) begin
          w_state_nxt  = ST_FWD;
          w_idx_nxt    = '0;
          w_fd_nxt     = C_ONE;
          w_target_nxt = target_in;
          w_infer_nxt  = infer_only_in;
        end
      end
      ST_FWD: begin
        if (r_idx == C_LAST_IDX) begin
          w_state_nxt = ST_LOSS;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
          w_fd_nxt  = C_ONE << w_idx_nxt;
        end
      end
      ST_LOSS: begin
        w_err_nxt = net_in ^ r_target;
        w_mis_nxt = |(net_in ^ r_target);
        if (r_infer) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_BWD;
          w_idx_nxt   = C_LAST_IDX;
          w_bk_nxt    = C_ONE << C_LAST_IDX;
        end
      end
      ST_BWD: begin
        if (r_idx == '0) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt = r_idx - 1'b1;
          w_bk_nxt  = C_ONE << w_idx_nxt;
        end
      end
      ST_DONE: begin
        // Statistics commit on leaving DONE so mismatch_out is already settled.
        w_state_nxt = ST_IDLE;
        w_scnt_nxt  = sample_cnt_out + 1'b1;
        if (mismatch_out) w_mcnt_nxt = mismatch_cnt_out + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Abort discards everything the current sample would have changed.
    if (abort_in && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_fd_nxt    = '0;
      w_bk_nxt    = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = err_out;
      w_mis_nxt   = mismatch_out;
      w_scnt_nxt  = sample_cnt_out;
      w_mcnt_nxt  = mismatch_cnt_out;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state          <= ST_IDLE;
      r_idx            <= '0;
      r_target         <= '0;
      r_infer          <= 1'b0;
      fd_prop_out      <= '0;
      bk_prop_out      <= '0;
      err_out          <= '0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      mismatch_out     <= 1'b0;
      sample_cnt_out   <= '0;
      mismatch_cnt_out <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_idx            <= w_idx_nxt;
      r_target         <= w_target_nxt;
      r_infer          <= w_infer_nxt;
      fd_prop_out      <= w_fd_nxt;
      bk_prop_out      <= w_bk_nxt;
      err_out          <= w_err_nxt;
      busy_out         <= (w_state_nxt != ST_IDLE);
      done_out         <= w_done_nxt;
      mismatch_out     <= w_mis_nxt;
      sample_cnt_out   <= w_scnt_nxt;
      mismatch_cnt_out <= w_mcnt_nxt;
    end
  end

endmodule
`default_nettype wire
